// File: rtl/rv32_mc_core.sv
// Multi-cycle RV32I core with req/ack instruction and data buses: FETCH, DECODE, EXECUTE, [MEM], WRITEBACK.
// Define RV_MC_MISALIGN_TRAP_EN to halt on misaligned data accesses or taken targets with bit1 set.
module rv32_mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 32,
  parameter int          DMEM_AW  = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        retire,
  output logic [31:0] retire_pc,
  output logic        halted
);

  localparam logic [31:0] IMASK = (IMEM_AW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << IMEM_AW) - 32'd1);
  localparam logic [31:0] DMASK = (DMEM_AW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << DMEM_AW) - 32'd1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q, instr_q, op1_q, op2_q, rs1_q, rs2_q, result_q, target_q;
  logic        taken_q;
  logic [1:0]  ea_lo_q;
  logic        imem_req_q, dmem_req_q, dmem_we_q, retire_q, halted_q;
  logic [31:0] imem_addr_q, dmem_addr_q, dmem_wdata_q, retire_pc_q;
  logic [3:0]  dmem_be_q;
  logic [31:0] rf_q [32];

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1a, rs2a;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, dec_imm, dec_op1, dec_op2;
  logic        dec_invalid, dec_rd_we;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_alu, is_op;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1a   = instr_q[19:15];
  assign rs2a   = instr_q[24:20];
  assign funct7 = instr_q[31:25];

  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_op     = (opcode == OPC_OP);
  assign is_alu    = is_op || (opcode == OPC_OPIMM);

  // x0 is never written, so its entry reads zero after reset
  assign rs1_val = rf_q[rs1a];
  assign rs2_val = rf_q[rs2a];

  always_comb begin
    dec_invalid = 1'b0;
    dec_rd_we   = 1'b0;
    dec_imm     = {{20{instr_q[31]}}, instr_q[31:20]};
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_imm   = {instr_q[31:12], 12'b0};
        dec_rd_we = 1'b1;
      end
      OPC_JAL: begin
        dec_imm   = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
        dec_rd_we = 1'b1;
      end
      OPC_JALR: begin
        dec_invalid = (funct3 != 3'b000);
        dec_rd_we   = 1'b1;
      end
      OPC_BRANCH: begin
        dec_imm     = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
        dec_invalid = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        dec_invalid = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        dec_rd_we   = 1'b1;
      end
      OPC_STORE: begin
        dec_imm     = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
        dec_invalid = (funct3[2] || funct3[1:0] == 2'b11);
      end
      OPC_OPIMM: begin
        dec_rd_we = 1'b1;
        if (funct3 == 3'b001)
          dec_invalid = (funct7 != 7'h00);
        else if (funct3 == 3'b101)
          dec_invalid = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OPC_OP: begin
        dec_rd_we   = 1'b1;
        dec_invalid = !((funct7 == 7'h00) ||
                        (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_FENCE: dec_invalid = 1'b0;
      default:   dec_invalid = 1'b1;
    endcase
  end

  always_comb begin
    dec_op1 = rs1_val;
    dec_op2 = dec_imm;
    if (is_lui)   dec_op1 = 32'd0;
    if (is_auipc) dec_op1 = pc_q;
    if (is_op)    dec_op2 = rs2_val;
  end

  logic [31:0] alu_res, pc_plus4, ex_result, ex_target_raw, ex_target, ea;
  logic [4:0]  shamt;
  logic        br_cond, ex_taken, ex_trap, is_mem;

  assign shamt = op2_q[4:0];

  always_comb begin
    alu_res = op1_q + op2_q;
    if (is_alu) begin
      case (funct3)
        3'b000: alu_res = (is_op && funct7[5]) ? op1_q - op2_q : op1_q + op2_q;
        3'b001: alu_res = op1_q << shamt;
        3'b010: alu_res = {31'd0, $signed(op1_q) < $signed(op2_q)};
        3'b011: alu_res = {31'd0, op1_q < op2_q};
        3'b100: alu_res = op1_q ^ op2_q;
        3'b101: alu_res = funct7[5] ? 32'($signed(op1_q) >>> shamt) : op1_q >> shamt;
        3'b110: alu_res = op1_q | op2_q;
        3'b111: alu_res = op1_q & op2_q;
      endcase
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  br_cond = (rs1_q == rs2_q);
      3'b001:  br_cond = (rs1_q != rs2_q);
      3'b100:  br_cond = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  br_cond = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  br_cond = (rs1_q <  rs2_q);
      3'b111:  br_cond = (rs1_q >= rs2_q);
      default: br_cond = 1'b0;
    endcase
  end

  assign pc_plus4      = pc_q + 32'd4;
  assign ex_result     = (is_jal || is_jalr) ? pc_plus4 : alu_res;
  assign ex_taken      = is_branch ? br_cond : (is_jal || is_jalr);
  assign ex_target_raw = is_jalr ? ((rs1_q + dec_imm) & ~32'd1) : (pc_q + dec_imm);
  assign ea            = alu_res;
  assign is_mem        = is_load || is_store;

`ifdef RV_MC_MISALIGN_TRAP_EN
  assign ex_target = ex_target_raw;
  assign ex_trap   = (ex_taken && ex_target_raw[1]) ||
                     (is_mem && ((funct3[1:0] == 2'b01 && ea[0]) ||
                                 (funct3[1:0] == 2'b10 && ea[1:0] != 2'b00)));
`else
  assign ex_target = {ex_target_raw[31:2], 1'b0, ex_target_raw[0]};
  assign ex_trap   = 1'b0;
`endif

  logic [3:0]  ex_be;
  logic [31:0] ex_wdata, ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // The byte-enable shift leaves the unused low address bits out of H/W lane selection
  always_comb begin
    case (funct3[1:0])
      2'b00:   begin ex_be = 4'b0001 << ea[1:0];         ex_wdata = {4{rs2_q[7:0]}};  end
      2'b01:   begin ex_be = 4'b0011 << {ea[1], 1'b0};   ex_wdata = {2{rs2_q[15:0]}}; end
      default: begin ex_be = 4'b1111;                    ex_wdata = rs2_q;            end
    endcase
  end

  assign ld_byte = dmem_rdata[{ea_lo_q, 3'b000} +: 8];
  assign ld_half = ea_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (funct3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = dmem_rdata;
    endcase
  end

  logic rf_we;
  assign rf_we = (state_q == S_WB) && dec_rd_we && (rd != 5'd0);

  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (rst)
        rf_q[i] <= '0;
      else if (rf_we && rd == 5'(i))
        rf_q[i] <= result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      result_q     <= '0;
      target_q     <= '0;
      taken_q      <= 1'b0;
      ea_lo_q      <= '0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_be_q    <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      retire_q     <= 1'b0;
      retire_pc_q  <= '0;
      halted_q     <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          // First cycle after reset raises the request; acks without a request are ignored
          if (!imem_req_q) begin
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_q & IMASK;
          end else if (imem_ack) begin
            imem_req_q <= 1'b0;
            instr_q    <= imem_rdata;
            state_q    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_invalid) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            rs1_q   <= rs1_val;
            rs2_q   <= rs2_val;
            op1_q   <= dec_op1;
            op2_q   <= dec_op2;
            state_q <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          taken_q  <= ex_taken;
          target_q <= ex_target;
          if (ex_trap) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else if (is_mem) begin
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= is_store;
            dmem_be_q    <= ex_be;
            dmem_addr_q  <= {ea[31:2], 2'b00} & DMASK;
            dmem_wdata_q <= is_store ? ex_wdata : 32'd0;
            ea_lo_q      <= ea[1:0];
            state_q      <= S_MEM;
          end else begin
            result_q    <= ex_result;
            retire_q    <= 1'b1;
            retire_pc_q <= pc_q;
            state_q     <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            result_q    <= ld_val;
            retire_q    <= 1'b1;
            retire_pc_q <= pc_q;
            state_q     <= S_WB;
          end
        end
        S_WB: begin
          pc_q        <= taken_q ? target_q : pc_plus4;
          imem_req_q  <= 1'b1;
          imem_addr_q <= (taken_q ? target_q : pc_plus4) & IMASK;
          state_q     <= S_FETCH;
        end
        default: begin
          state_q  <= S_HALT;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign retire     = retire_q;
  assign retire_pc  = retire_pc_q;
  assign halted     = halted_q;

endmodule
